// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// request/ready handshake and drives the IF/ID register toward decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          PC_STEP      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] instrAddress,
    output logic        instrRequest,
    input  logic        instrReady,
    input  logic [31:0] instrData,
    output logic [31:0] instruction,
    output logic [31:0] programCounterOut,
    output logic        instructionValid
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetchState;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus;
        logic        valid;
    } ifIdReg;

    localparam ifIdReg BUBBLE = '{instr: 32'h0, pcPlus: 32'h0, valid: 1'b0};

    fetchState   state, stateNext;
    ifIdReg      ifId, ifIdNext;
    logic [31:0] pc, pcNext;
    logic [31:0] pcPlusStep;
    logic [31:0] abandonAddr, abandonNext;
    logic [31:0] holdBuf, holdNext;
    logic [31:0] redirectPc;

    assign pcPlusStep = pc + STEP;
    assign redirectPc = {branchTarget[31:2], 2'b00};

    // Memory side is driven from registered state only.
    assign instrRequest = (state == FETCH) || (state == DISCARD);
    assign instrAddress = (state == DISCARD) ? abandonAddr : pc;

    assign instruction       = ifId.instr;
    assign programCounterOut = ifId.pcPlus;
    assign instructionValid  = ifId.valid;

    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        abandonNext = abandonAddr;
        holdNext    = holdBuf;
        ifIdNext    = ifId;

        if (branchTaken) begin
            // Flush beats stall; an in-flight request must still be drained.
            ifIdNext = BUBBLE;
            pcNext   = redirectPc;
            holdNext = 32'h0;
            unique case (state)
                FETCH: begin
                    if (!instrReady) begin
                        stateNext   = DISCARD;
                        abandonNext = pc;
                    end else begin
                        stateNext = FETCH;
                    end
                end
                DISCARD: stateNext = DISCARD;
                default: stateNext = FETCH;
            endcase
        end else begin
            unique case (state)
                IDLE: stateNext = FETCH;
                FETCH: begin
                    if (instrReady && !stall) begin
                        ifIdNext = '{instr: instrData, pcPlus: pcPlusStep, valid: 1'b1};
                        pcNext   = pcPlusStep;
                    end else if (instrReady) begin
                        holdNext  = instrData;
                        stateNext = HOLD;
                    end else if (!stall) begin
                        ifIdNext = BUBBLE;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifIdNext  = '{instr: holdBuf, pcPlus: pcPlusStep, valid: 1'b1};
                        pcNext    = pcPlusStep;
                        stateNext = FETCH;
                    end
                end
                DISCARD: begin
                    ifIdNext = BUBBLE;
                    if (instrReady) stateNext = FETCH;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            abandonAddr <= 32'h0;
            holdBuf     <= 32'h0;
            ifId        <= BUBBLE;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            abandonAddr <= abandonNext;
            holdBuf     <= holdNext;
            ifId        <= ifIdNext;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the fetch stage.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, branchTaken, instrReady, instrRequest, instructionValid;
    logic [31:0] branchTarget, instrAddress, instrData, instruction, programCounterOut;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_VECTOR(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
        .branchTarget(branchTarget), .instrAddress(instrAddress),
        .instrRequest(instrRequest), .instrReady(instrReady), .instrData(instrData),
        .instruction(instruction), .programCounterOut(programCounterOut),
        .instructionValid(instructionValid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    // Model: the stage is either waking up, fetching at mPc, sitting on a word
    // it could not hand over, or draining a request it no longer wants.
    logic [31:0] mPc, mDropAddr, mHeldWord, mIns, mPco;
    logic        mWaking, mHeld, mDropping, mVal;

    function automatic logic expReq();
        return !mWaking && !mHeld;
    endfunction

    function automatic logic [31:0] expAddr();
        return mDropping ? mDropAddr : mPc;
    endfunction

    task automatic modelStep(input logic rst, rdy, stl, br, input logic [31:0] tgt,
                             input logic [31:0] data);
        if (rst) begin
            mPc = 32'h0; mWaking = 1; mHeld = 0; mDropping = 0;
            mIns = 0; mPco = 0; mVal = 0;
        end else if (br) begin
            if (!mWaking && !mHeld && !mDropping && !rdy) begin
                mDropping = 1; mDropAddr = mPc;
            end
            mWaking = 0; mHeld = 0;
            mPc = tgt & 32'hFFFF_FFFC;
            mIns = 0; mPco = 0; mVal = 0;
        end else if (mWaking) begin
            mWaking = 0;
        end else if (mHeld) begin
            if (!stl) begin
                mIns = mHeldWord; mPco = mPc + 4; mVal = 1;
                mPc = mPc + 4; mHeld = 0;
            end
        end else if (mDropping) begin
            mIns = 0; mPco = 0; mVal = 0;
            if (rdy) mDropping = 0;
        end else begin
            if (rdy && !stl) begin
                mIns = data; mPco = mPc + 4; mVal = 1; mPc = mPc + 4;
            end else if (rdy) begin
                mHeldWord = data; mHeld = 1;
            end else if (!stl) begin
                mIns = 0; mPco = 0; mVal = 0;
            end
        end
    endtask

    task automatic compareAll();
        chk("instrRequest", 32'(instrRequest), 32'(expReq()));
        if (expReq()) chk("instrAddress", instrAddress, expAddr());
        chk("instruction", instruction, mIns);
        chk("programCounterOut", programCounterOut, mPco);
        chk("instructionValid", 32'(instructionValid), 32'(mVal));
    endtask

    task automatic step(input logic rst, rdy, stl, br, input logic [31:0] tgt);
        logic [31:0] d;
        d = rdy ? memWord(expAddr()) : $urandom;
        reset = rst; instrReady = rdy; stall = stl; branchTaken = br;
        branchTarget = tgt; instrData = d;
        @(posedge clk);
        modelStep(rst, rdy, stl, br, tgt, d);
        @(negedge clk);
        compareAll();
    endtask

    initial begin
        reset = 1; stall = 0; branchTaken = 0; instrReady = 0;
        branchTarget = 0; instrData = 0;
        step(1, 1, 1, 1, 32'h55);
        step(1, 0, 0, 0, 0);
        chk("resetValid", 32'(instructionValid), 32'h0);
        chk("resetReq", 32'(instrRequest), 32'h0);

        // zero-wait memory: valid from the second cycle after release
        step(0, 1, 0, 0, 0);
        chk("latencyReq", 32'(instrRequest), 32'h1);
        chk("latencyAddr", instrAddress, 32'h0);
        step(0, 1, 0, 0, 0);
        chk("firstValid", 32'(instructionValid), 32'h1);
        chk("firstPco", programCounterOut, 32'h4);
        step(0, 1, 0, 0, 0);
        chk("secondPco", programCounterOut, 32'h8);
        // wait states on address 8
        repeat (3) step(0, 0, 0, 0, 0);
        chk("waitAddr", instrAddress, 32'h8);
        step(0, 1, 0, 0, 0);
        chk("afterWaitPco", programCounterOut, 32'hC);

        // stall while a response arrives, then release
        step(0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        chk("holdNoReq", 32'(instrRequest), 32'h0);
        step(0, 0, 0, 0, 0);
        chk("holdReleasePco", programCounterOut, 32'h10);
        chk("holdReleaseIns", instruction, memWord(32'hC));

        // redirect while the request is pending: drain, then fetch the target
        step(0, 0, 0, 1, 32'h0000_0103);
        chk("drainAddr", instrAddress, 32'h10);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("targetAddr", instrAddress, 32'h100);
        step(0, 1, 0, 0, 0);

        // flush wins over stall
        step(0, 1, 1, 1, 32'h0000_0200);
        chk("flushValid", 32'(instructionValid), 32'h0);
        chk("flushAddr", instrAddress, 32'h200);

        // PC wrap at the top of the address space
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        step(0, 1, 0, 0, 0);
        chk("wrapPco", programCounterOut, 32'h0);
        chk("wrapAddr", instrAddress, 32'h0);

        // reset in the middle of a wait
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("midResetValid", 32'(instructionValid), 32'h0);
        step(0, 1, 0, 0, 0);
        chk("restartAddr", instrAddress, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
